laser_cover_scorer: RTL and testbench

- Downstream checker for the two-circle laser solver.
- Keeps its own copy of the 40-point frame and, once the solver reports its centres, counts how many stored points the union of both circles covers.
- Covered means squared Euclidean distance ≤ RADIUS_SQ.
- Feeds the score to the frame-level controller and self-check logic; one point is evaluated per cycle.

---
 rtl/laser_cover_scorer.sv | 148 ++++++++++++++
 tb/tb_laser_cover_scorer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_cover_scorer.sv
// Two-circle coverage scorer: stores a frame of points, then counts the points covered by either circle.
// Optional COVER_SPLIT_EN adds per-circle counts CNT1/CNT2.
module laser_cover_scorer #(
    parameter int NUM_PTS   = 40,
    parameter int RADIUS_SQ = 16,
    parameter int CW        = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PT_VALID,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic          DONE,
    input  logic [CW-1:0] C1X,
    input  logic [CW-1:0] C1Y,
    input  logic [CW-1:0] C2X,
    input  logic [CW-1:0] C2Y,
    output logic [5:0]    SCORE,
    output logic          SCORE_VALID,
    output logic          BUSY
`ifdef COVER_SPLIT_EN
    ,
    output logic [5:0]    CNT1,
    output logic [5:0]    CNT2
`endif
);

    localparam int IW = $clog2(NUM_PTS);
    localparam logic [IW-1:0] LAST = IW'(NUM_PTS - 1);
    localparam int DW = 2 * CW + 1;
    localparam logic [DW-1:0] RSQ = DW'(RADIUS_SQ);

    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_EVAL, S_OUT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [5:0]    acc;
    logic          done_d;
    logic          done_rise;
    logic [CW-1:0] c1x, c1y, c2x, c2y;
    logic [CW-1:0] pbuf_x [NUM_PTS];
    logic [CW-1:0] pbuf_y [NUM_PTS];
    logic          hit1, hit2, hit;

    function automatic logic [DW-1:0] dist_sq(input logic [CW-1:0] px, py, cx, cy);
        logic [CW-1:0] dx, dy;
        logic [DW-1:0] ex, ey;
        dx = (px >= cx) ? px - cx : cx - px;
        dy = (py >= cy) ? py - cy : cy - py;
        ex = DW'(dx);
        ey = DW'(dy);
        return ex * ex + ey * ey;
    endfunction

    assign done_rise = DONE & ~done_d;

    always_comb begin
        hit1 = (dist_sq(pbuf_x[idx], pbuf_y[idx], c1x, c1y) <= RSQ);
        hit2 = (dist_sq(pbuf_x[idx], pbuf_y[idx], c2x, c2y) <= RSQ);
        hit  = hit1 | hit2;
    end

    always_ff @(posedge CLK) begin
        if (!RST) state <= S_LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (PT_VALID && idx == LAST) state_nxt = S_WAIT;
            S_WAIT: if (done_rise)               state_nxt = S_EVAL;
            S_EVAL: if (idx == LAST)             state_nxt = S_OUT;
            S_OUT:                               state_nxt = S_LOAD;
            default:                             state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        BUSY = (state == S_EVAL) || (state == S_OUT);
    end

    // Frame buffer carries no reset; every entry is rewritten in LOAD before use.
    always_ff @(posedge CLK) begin
        if (RST && state == S_LOAD && PT_VALID) begin
            pbuf_x[idx] <= X;
            pbuf_y[idx] <= Y;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            idx         <= '0;
            acc         <= '0;
            done_d      <= 1'b1;
            SCORE       <= '0;
            SCORE_VALID <= 1'b0;
            c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
        end else begin
            done_d      <= DONE;
            SCORE_VALID <= 1'b0;
            case (state)
                S_LOAD: if (PT_VALID) idx <= (idx == LAST) ? '0 : idx + 1'b1;
                S_WAIT: if (done_rise) begin
                    c1x <= C1X; c1y <= C1Y; c2x <= C2X; c2y <= C2Y;
                    acc <= '0;
                    idx <= '0;
                end
                S_EVAL: begin
                    acc <= acc + {5'b0, hit};
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                S_OUT: begin
                    SCORE       <= acc;
                    SCORE_VALID <= 1'b1;
                    idx         <= '0;
                end
                default: idx <= '0;
            endcase
        end
    end

`ifdef COVER_SPLIT_EN
    logic [5:0] acc1, acc2;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc1 <= '0; acc2 <= '0;
            CNT1 <= '0; CNT2 <= '0;
        end else begin
            case (state)
                S_WAIT: if (done_rise) begin
                    acc1 <= '0; acc2 <= '0;
                end
                S_EVAL: begin
                    acc1 <= acc1 + {5'b0, hit1};
                    acc2 <= acc2 + {5'b0, hit2};
                end
                S_OUT: begin
                    CNT1 <= acc1; CNT2 <= acc2;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_laser_cover_scorer.sv
// Scoreboard bench for laser_cover_scorer: a coverage model pushes expected scores when DONE rises.
module tb_laser_cover_scorer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       PT_VALID = 1'b0;
    logic [3:0] X = '0, Y = '0;
    logic       DONE = 1'b0;
    logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic [5:0] SCORE;
    logic       SCORE_VALID;
    logic       BUSY;
`ifdef COVER_SPLIT_EN
    logic [5:0] CNT1, CNT2;
`endif

    laser_cover_scorer #(.NUM_PTS(40), .RADIUS_SQ(16), .CW(4)) dut (
        .CLK(CLK), .RST(RST), .PT_VALID(PT_VALID), .X(X), .Y(Y), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .SCORE(SCORE), .SCORE_VALID(SCORE_VALID), .BUSY(BUSY)
`ifdef COVER_SPLIT_EN
        , .CNT1(CNT1), .CNT2(CNT2)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int score;
        int c1;
        int c2;
    } exp_t;

    exp_t sb[$];
    int   px[40], py[40];
    int   total = 0;
    int   bad   = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_frame(input bit gaps);
        for (int i = 0; i < 40; i++) begin
            X = px[i][3:0]; Y = py[i][3:0]; PT_VALID = 1'b1;
            step();
            if (gaps) begin
                PT_VALID = 1'b0; X = 4'hF - X; Y = 4'hF - Y;
                step();
            end
        end
        PT_VALID = 1'b0;
    endtask

    function automatic exp_t model(input int ax, ay, bx, by);
        exp_t e;
        e.score = 0; e.c1 = 0; e.c2 = 0;
        for (int i = 0; i < 40; i++) begin
            bit in1, in2;
            in1 = ((px[i]-ax)*(px[i]-ax) + (py[i]-ay)*(py[i]-ay)) <= 16;
            in2 = ((px[i]-bx)*(px[i]-bx) + (py[i]-by)*(py[i]-by)) <= 16;
            e.c1 += int'(in1);
            e.c2 += int'(in2);
            e.score += int'(in1 || in2);
        end
        return e;
    endfunction

    // Returns after edge 0 (the edge that samples the DONE rise).
    task automatic fire(input int ax, ay, bx, by);
        DONE = 1'b0;
        step();
        C1X = ax[3:0]; C1Y = ay[3:0]; C2X = bx[3:0]; C2Y = by[3:0];
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        sb.push_back(model(ax, ay, bx, by));
    endtask

    task automatic collect(input bit noise, output bit got, output int lat,
                           output int sc, output int n1, output int n2);
        got = 1'b0; lat = 0; sc = 0; n1 = 0; n2 = 0;
        for (int n = 1; n <= 60; n++) begin
            if (noise) begin
                PT_VALID = ~PT_VALID; X = 4'($urandom); Y = 4'($urandom);
            end
            step();
            if (SCORE_VALID) begin
                got = 1'b1; lat = n; sc = int'(SCORE);
`ifdef COVER_SPLIT_EN
                n1 = int'(CNT1); n2 = int'(CNT2);
`endif
                break;
            end
        end
        PT_VALID = 1'b0;
    endtask

    task automatic fill(input int x, y);
        for (int i = 0; i < 40; i++) begin px[i] = x; py[i] = y; end
    endtask

    task automatic test_reset();
        RST = 1'b0; DONE = 1'b1;
        step(); step();
        total++;
        if (SCORE !== 6'd0 || SCORE_VALID !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got score=%0d valid=%b busy=%b, need 0/0/0", SCORE, SCORE_VALID, BUSY);
        end
        RST = 1'b1;
        step();
    endtask

    task automatic test_done_held();
        bit got; int lat, sc, n1, n2, pulses;
        exp_t e;
        fill(7, 3);
        load_frame(1'b0);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (SCORE_VALID || BUSY) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL held_done_no_rise: got %0d active cycles, need 0", pulses);
        end
        fire(3, 3, 15, 15);
        total++;
        if (BUSY !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_eval: got %b, need 1", BUSY);
        end
        collect(1'b0, got, lat, sc, n1, n2);
        e = sb.pop_front();
        total++;
        if (!got || lat != 41) begin
            bad++;
            $display("FAIL latency: got valid=%b at edge %0d, need edge 41", got, lat);
        end
        total++;
        if (sc != e.score) begin
            bad++;
            $display("FAIL boundary_d16: got %0d, need %0d", sc, e.score);
        end
    endtask

    task automatic test_boundary();
        bit got; int lat, sc, n1, n2;
        exp_t e;
        fill(6, 6);
        load_frame(1'b0);
        fire(3, 3, 15, 15);
        collect(1'b0, got, lat, sc, n1, n2);
        e = sb.pop_front();
        total++;
        if (!got || sc != e.score) begin
            bad++;
            $display("FAIL boundary_d18: got valid=%b score=%0d, need %0d", got, sc, e.score);
        end
    endtask

    task automatic test_union();
        bit got; int lat, sc, n1, n2;
        exp_t e;
        fill(8, 8);
        load_frame(1'b0);
        fire(6, 8, 10, 8);
        collect(1'b0, got, lat, sc, n1, n2);
        e = sb.pop_front();
        total++;
        if (!got || sc != e.score) begin
            bad++;
            $display("FAIL union_overlap: got valid=%b score=%0d, need %0d", got, sc, e.score);
        end
`ifdef COVER_SPLIT_EN
        total++;
        if (n1 != e.c1 || n2 != e.c2) begin
            bad++;
            $display("FAIL split_counts: got %0d/%0d, need %0d/%0d", n1, n2, e.c1, e.c2);
        end
`endif
    endtask

    task automatic test_gaps_and_noise();
        bit got; int lat, sc, n1, n2;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            px[i] = int'($urandom_range(2, 9)); py[i] = int'($urandom_range(2, 9));
        end
        load_frame(1'b1);
        for (int i = 0; i < 5; i++) begin
            PT_VALID = 1'b1; X = 4'd15; Y = 4'd0;
            step();
        end
        PT_VALID = 1'b0;
        fire(4, 4, 8, 7);
        collect(1'b1, got, lat, sc, n1, n2);
        e = sb.pop_front();
        total++;
        if (!got || sc != e.score) begin
            bad++;
            $display("FAIL gapped_load_noise: got valid=%b score=%0d, need %0d", got, sc, e.score);
        end
        load_frame(1'b0);
        fire(8, 7, 3, 3);
        collect(1'b0, got, lat, sc, n1, n2);
        e = sb.pop_front();
        total++;
        if (!got || sc != e.score) begin
            bad++;
            $display("FAIL reload_after_noise: got valid=%b score=%0d, need %0d", got, sc, e.score);
        end
    endtask

    task automatic test_mixed();
        bit got; int lat, sc, n1, n2;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 40; i++) begin
                px[i] = (i < 20) ? 0 : 15; py[i] = px[i];
            end
            load_frame(1'b0);
            if (pass == 0) fire(1, 1, 14, 14);
            else           fire(1, 1, 1, 1);
            collect(1'b0, got, lat, sc, n1, n2);
            e = sb.pop_front();
            total++;
            if (!got || sc != e.score) begin
                bad++;
                $display("FAIL mixed_frame_%0d: got valid=%b score=%0d, need %0d", pass, got, sc, e.score);
            end
        end
    endtask

    task automatic test_reset_mid_eval();
        bit got; int lat, sc, n1, n2, pulses;
        exp_t e;
        fill(5, 5);
        load_frame(1'b0);
        fire(5, 5, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 20; i++) step();
        RST = 1'b0;
        step();
        total++;
        if (SCORE !== 6'd0 || BUSY !== 1'b0 || SCORE_VALID !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_eval: got score=%0d busy=%b valid=%b, need 0/0/0", SCORE, BUSY, SCORE_VALID);
        end
        RST = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (SCORE_VALID) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL partial_publish: got %0d pulses, need 0", pulses);
        end
        for (int i = 0; i < 40; i++) begin px[i] = i % 16; py[i] = (3 * i) % 16; end
        load_frame(1'b0);
        fire(4, 6, 11, 9);
        collect(1'b0, got, lat, sc, n1, n2);
        e = sb.pop_front();
        total++;
        if (!got || lat != 41 || sc != e.score) begin
            bad++;
            $display("FAIL fresh_after_reset: got valid=%b lat=%0d score=%0d, need 41/%0d", got, lat, sc, e.score);
        end
    endtask

    initial begin
        test_reset();
        test_done_held();
        test_boundary();
        test_union();
        test_gaps_and_noise();
        test_mixed();
        test_reset_mid_eval();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
